// File: rtl/conv_pkg.sv
// Shared constants, FSM encoding and constant-ROM helpers for the systolic
// convolution engine.
package conv_pkg;

  localparam int DATA_W = 8;
  localparam int ACC_W  = 18;
  localparam int IMG    = 4;
  localparam int K      = 2;
  localparam int OUT    = IMG - K + 1;
  localparam int NPE    = K * K;
  localparam int NRES   = OUT * OUT;

  localparam int LEN_W = 4;
  localparam int LEN_X = 16;
  localparam int LEN_C = 9;
  localparam int LEN_D = 4;

  localparam logic [4:0] LAST_W = 5'(LEN_W - 1);
  localparam logic [4:0] LAST_X = 5'(LEN_X - 1);
  localparam logic [4:0] LAST_C = 5'(LEN_C - 1);
  localparam logic [4:0] LAST_D = 5'(LEN_D - 1);

  typedef enum logic [6:0] {
    IDLE    = 7'b0000001,
    LOAD_W  = 7'b0000010,
    LOAD_X  = 7'b0000100,
    COMPUTE = 7'b0001000,
    DRAIN   = 7'b0010000,
    STORE   = 7'b0100000,
    DONE    = 7'b1000000
  } state_t;

  // Image ROM: row-major address a holds a+1.
  function automatic logic [DATA_W-1:0] rom_x(input logic [3:0] addr);
    logic [DATA_W-1:0] v;
    v = {{(DATA_W-4){1'b0}}, addr};
    return v + {{(DATA_W-1){1'b0}}, 1'b1};
  endfunction

  // Weight ROM: tap t holds t+1.
  function automatic logic [DATA_W-1:0] rom_w(input logic [1:0] tap);
    logic [DATA_W-1:0] v;
    v = {{(DATA_W-2){1'b0}}, tap};
    return v + {{(DATA_W-1){1'b0}}, 1'b1};
  endfunction

  // Image address of the top-left tap for output pixel n = (n/3, n%3).
  function automatic logic [3:0] tap_base(input logic [3:0] n);
    logic [3:0] b;
    case (n)
      4'd0:    b = 4'd0;
      4'd1:    b = 4'd1;
      4'd2:    b = 4'd2;
      4'd3:    b = 4'd4;
      4'd4:    b = 4'd5;
      4'd5:    b = 4'd6;
      4'd6:    b = 4'd8;
      4'd7:    b = 4'd9;
      4'd8:    b = 4'd10;
      default: b = 4'd0;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/conv_pe.sv
// One weight-stationary MAC stage: psum_out = psum_in + w * x, registered.
// mac_o exposes the same sum before the register for the last stage's sink.
module conv_pe
  import conv_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              w_ld,
  input  logic [DATA_W-1:0] w_in,
  input  logic [DATA_W-1:0] x_in,
  input  logic [ACC_W-1:0]  psum_in,
  output logic [ACC_W-1:0]  psum_o,
  output logic [ACC_W-1:0]  mac_o
);

  logic [DATA_W-1:0]   w_q, w_d;
  logic [ACC_W-1:0]    psum_q, psum_d;
  logic [2*DATA_W-1:0] prod_s;

  // Weight hold/load and the multiply-accumulate.
  always_comb begin
    w_d    = w_q;
    prod_s = w_q * x_in;
    if (w_ld) begin
      w_d = w_in;
    end else begin
      w_d = w_q;
    end
    psum_d = psum_in + {{(ACC_W-2*DATA_W){1'b0}}, prod_s};
  end

  // Weight and partial-sum registers with synchronous clear.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      w_q    <= '0;
      psum_q <= '0;
    end else begin
      w_q    <= w_d;
      psum_q <= psum_d;
    end
  end

  assign psum_o = psum_q;
  assign mac_o  = psum_d;

endmodule

// File: rtl/systolic_conv_top.sv
// Self-starting 2x2-over-4x4 valid convolution: FSM, shared phase counter,
// image register file, tap skew, 4-PE MAC chain and the 3x3 result bank.
module systolic_conv_top
  import conv_pkg::*;
(
  input  logic       CLK,
  input  logic       RST,
  output logic [6:0] STATE,
  output logic [6:0] NEXT_STATE
);

  state_t            state_q, state_d;
  logic [4:0]        cnt_q, cnt_d;
  logic [DATA_W-1:0] img_q [IMG*IMG];
  logic [DATA_W-1:0] img_d [IMG*IMG];
  logic [DATA_W-1:0] sk1_q, sk1_d;
  logic [DATA_W-1:0] sk2_q [2];
  logic [DATA_W-1:0] sk2_d [2];
  logic [DATA_W-1:0] sk3_q [3];
  logic [DATA_W-1:0] sk3_d [3];
  logic [2:0]        vld_q, vld_d;
  logic [3:0]        idx_q [3];
  logic [3:0]        idx_d [3];
  logic [ACC_W-1:0]  res   [NRES];
  logic [ACC_W-1:0]  res_d [NRES];

  logic              in_compute_s;
  logic [3:0]        base_s;
  logic [DATA_W-1:0] tap_s   [NPE];
  logic [DATA_W-1:0] pe_x_s  [NPE];
  logic [NPE-1:0]    w_ld_s;
  logic [DATA_W-1:0] w_rom_s;
  logic [ACC_W-1:0]  chain_s [NPE+1];
  logic [ACC_W-1:0]  mac_s   [NPE];

  assign STATE      = state_q;
  assign NEXT_STATE = state_d;

  // Phase sequencing; each phase ends when the shared counter hits its last cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = LOAD_W;
      LOAD_W:  if (cnt_q == LAST_W) state_d = LOAD_X;  else state_d = state_q;
      LOAD_X:  if (cnt_q == LAST_X) state_d = COMPUTE; else state_d = state_q;
      COMPUTE: if (cnt_q == LAST_C) state_d = DRAIN;   else state_d = state_q;
      DRAIN:   if (cnt_q == LAST_D) state_d = STORE;   else state_d = state_q;
      STORE:   state_d = DONE;
      DONE:    state_d = DONE;
      default: state_d = IDLE;
    endcase
    if (!RST) begin
      state_d = IDLE;
    end else begin
      state_d = state_d;
    end
  end

  // Shared cycle counter, zero on every state entry, parked in DONE.
  always_comb begin
    cnt_d = cnt_q + 5'd1;
    if (state_d != state_q) begin
      cnt_d = 5'd0;
    end else if (state_q == DONE) begin
      cnt_d = cnt_q;
    end else begin
      cnt_d = cnt_q + 5'd1;
    end
  end

  // ROM addressing, tap fetch, skew alignment and result write-back.
  always_comb begin
    in_compute_s = (state_q == COMPUTE);
    base_s       = tap_base(cnt_q[3:0]);
    w_rom_s      = rom_w(cnt_q[1:0]);
    for (int k = 0; k < NPE; k++) begin
      w_ld_s[k] = (state_q == LOAD_W) && (cnt_q[1:0] == 2'(k));
    end

    img_d = img_q;
    if (state_q == LOAD_X) begin
      img_d[cnt_q[3:0]] = rom_x(cnt_q[3:0]);
    end else begin
      img_d = img_q;
    end

    // Outside COMPUTE zeros flow into the chain so DRAIN flushes cleanly.
    if (in_compute_s) begin
      tap_s[0] = img_q[base_s];
      tap_s[1] = img_q[base_s + 4'd1];
      tap_s[2] = img_q[base_s + 4'd4];
      tap_s[3] = img_q[base_s + 4'd5];
    end else begin
      for (int k = 0; k < NPE; k++) tap_s[k] = '0;
    end

    sk1_d    = tap_s[1];
    sk2_d[0] = tap_s[2];
    sk2_d[1] = sk2_q[0];
    sk3_d[0] = tap_s[3];
    sk3_d[1] = sk3_q[0];
    sk3_d[2] = sk3_q[1];

    pe_x_s[0] = tap_s[0];
    pe_x_s[1] = sk1_q;
    pe_x_s[2] = sk2_q[1];
    pe_x_s[3] = sk3_q[2];

    vld_d    = {vld_q[1:0], in_compute_s};
    idx_d[0] = cnt_q[3:0];
    idx_d[1] = idx_q[0];
    idx_d[2] = idx_q[1];
    if (state_q == STORE) begin
      vld_d = 3'b000;
    end else begin
      vld_d = vld_d;
    end

    res_d = res;
    if (vld_q[2]) begin
      res_d[idx_q[2]] = mac_s[NPE-1];
    end else begin
      res_d = res;
    end
  end

  assign chain_s[0] = '0;

  for (genvar k = 0; k < NPE; k++) begin : g_pe
    conv_pe u_pe (
      .clk     (CLK),
      .rst_n   (RST),
      .w_ld    (w_ld_s[k]),
      .w_in    (w_rom_s),
      .x_in    (pe_x_s[k]),
      .psum_in (chain_s[k]),
      .psum_o  (chain_s[k+1]),
      .mac_o   (mac_s[k])
    );
  end

  // All engine state, cleared by the synchronous active-low reset.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_q <= IDLE;
      cnt_q   <= 5'd0;
      sk1_q   <= '0;
      vld_q   <= 3'b000;
      for (int i = 0; i < IMG*IMG; i++) img_q[i] <= '0;
      for (int i = 0; i < 2; i++) sk2_q[i] <= '0;
      for (int i = 0; i < 3; i++) sk3_q[i] <= '0;
      for (int i = 0; i < 3; i++) idx_q[i] <= 4'd0;
      for (int i = 0; i < NRES; i++) res[i] <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sk1_q   <= sk1_d;
      vld_q   <= vld_d;
      img_q   <= img_d;
      sk2_q   <= sk2_d;
      sk3_q   <= sk3_d;
      idx_q   <= idx_d;
      res     <= res_d;
    end
  end

endmodule

// File: tb/tb_systolic_conv_top.sv
// Scoreboard bench: expected state trace and result writes are queued per run,
// a negedge monitor pops and compares them as the engine advances.
module tb_systolic_conv_top;

  typedef struct packed {
    logic [6:0] st;
    logic [6:0] nx;
  } st_exp_t;

  typedef struct packed {
    logic [3:0]  idx;
    logic [17:0] val;
    logic [31:0] cyc;
  } wr_exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [6:0] state_w;
  logic [6:0] next_w;

  int n_checks = 0;
  int n_fail   = 0;

  st_exp_t     exp_st[$];
  wr_exp_t     exp_wr[$];
  logic [17:0] snap [9];
  logic        mon_en = 1'b0;
  int          mon_t  = 0;

  systolic_conv_top dut (
    .CLK        (clk),
    .RST        (rst),
    .STATE      (state_w),
    .NEXT_STATE (next_w)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic [6:0] exp_state(input int t);
    if (t == 0)      return 7'b0000001;
    else if (t < 5)  return 7'b0000010;
    else if (t < 21) return 7'b0000100;
    else if (t < 30) return 7'b0001000;
    else if (t < 34) return 7'b0010000;
    else if (t == 34) return 7'b0100000;
    else             return 7'b1000000;
  endfunction

  function automatic logic [17:0] exp_res(input int n);
    return 18'(40 * (n / 3) + 10 * (n % 3) + 44);
  endfunction

  // Call just after RST rises, before the negedge of cycle 0.
  task automatic start_run(input int ncyc);
    st_exp_t s;
    wr_exp_t w;
    exp_st.delete();
    exp_wr.delete();
    for (int t = 0; t < ncyc; t++) begin
      s.st = exp_state(t);
      s.nx = exp_state(t + 1);
      exp_st.push_back(s);
    end
    for (int n = 0; n < 9; n++) begin
      if (25 + n < ncyc) begin
        w.idx = 4'(n);
        w.val = exp_res(n);
        w.cyc = 32'(25 + n);
        exp_wr.push_back(w);
      end
    end
    for (int k = 0; k < 9; k++) snap[k] = dut.res[k];
    mon_t  = 0;
    mon_en = 1'b1;
  endtask

  task automatic wait_run(input string nm, input int ncyc);
    repeat (ncyc) @(negedge clk);
    #1;
    mon_en = 1'b0;
    chk({nm, "_state_sb_left"}, 32'(exp_st.size()), 32'd0);
    chk({nm, "_res_sb_left"}, 32'(exp_wr.size()), 32'd0);
  endtask

  task automatic check_res_final(input string nm);
    for (int k = 0; k < 9; k++) begin
      chk($sformatf("%s_res%0d", nm, k), {14'd0, dut.res[k]}, {14'd0, exp_res(k)});
    end
  endtask

  // Monitor: per-cycle state trace plus timestamped result-bank writes.
  always @(negedge clk) begin
    if (mon_en) begin
      st_exp_t s;
      wr_exp_t w;
      if (exp_st.size() == 0) begin
        chk("state_sb_underflow", 32'd1, 32'd0);
      end else begin
        s = exp_st.pop_front();
        chk($sformatf("state_c%0d", mon_t), {25'd0, state_w}, {25'd0, s.st});
        chk($sformatf("next_c%0d", mon_t), {25'd0, next_w}, {25'd0, s.nx});
      end
      chk($sformatf("onehot_c%0d", mon_t), 32'($countones(state_w)), 32'd1);
      for (int k = 0; k < 9; k++) begin
        if (dut.res[k] !== snap[k]) begin
          if (exp_wr.size() == 0) begin
            chk($sformatf("res_unexpected_write%0d", k), {14'd0, dut.res[k]}, {14'd0, snap[k]});
          end else begin
            w = exp_wr.pop_front();
            chk("res_write_idx", 32'(k), {28'd0, w.idx});
            chk($sformatf("res_write_val%0d", k), {14'd0, dut.res[k]}, {14'd0, w.val});
            chk($sformatf("res_write_cyc%0d", k), 32'(mon_t), w.cyc);
          end
          snap[k] = dut.res[k];
        end
      end
      mon_t++;
    end
  end

  initial begin
    rst = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_state", {25'd0, state_w}, 32'h01);
    chk("reset_next", {25'd0, next_w}, 32'h01);
    for (int k = 0; k < 9; k++) chk($sformatf("reset_res%0d", k), {14'd0, dut.res[k]}, 32'd0);

    // Full run, traced through cycle 120.
    @(posedge clk);
    #1 rst = 1'b1;
    start_run(121);
    wait_run("run1", 121);
    check_res_final("run1");

    // Fresh start, then reset for one edge at COMPUTE cycle 25.
    rst = 1'b0;
    @(posedge clk);
    #1 rst = 1'b1;
    start_run(26);
    wait_run("run2a", 26);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("midreset_state", {25'd0, state_w}, 32'h01);
    chk("midreset_next", {25'd0, next_w}, 32'h01);
    for (int k = 0; k < 9; k++) chk($sformatf("midreset_res%0d", k), {14'd0, dut.res[k]}, 32'd0);
    rst = 1'b1;
    start_run(40);
    wait_run("run2b", 40);
    check_res_final("run2b");

    // Reset while parked in DONE.
    rst = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("doneflush_state", {25'd0, state_w}, 32'h01);
      chk("doneflush_next", {25'd0, next_w}, 32'h01);
    end
    @(posedge clk);
    #1 rst = 1'b1;
    start_run(40);
    wait_run("run3", 40);
    check_res_final("run3");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
